// File: rtl/sm_register_pkg.sv
// Shared defaults for schoolMIPS state registers (program counter and friends).
package sm_register_pkg;

    localparam int          SM_REG_WIDTH_DEFAULT = 32;
    localparam logic [31:0] SM_REG_RESET_DEFAULT = 32'h0;

endpackage

// File: rtl/sm_register_we.sv
// Enable-gated D flop with asynchronous active-low clear; backs sm_register when
// SM_REGISTER_WE_EN is defined.
module sm_register_we
    import sm_register_pkg::*;
#(
    parameter int               WIDTH       = SM_REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SM_REG_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic             we
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sm_register.sv
// sm_register: generic D-type state register of the schoolMIPS core (holds the PC).
// Macro SM_REGISTER_WE_EN adds a trailing write-enable port; default build loads every cycle.
module sm_register
    import sm_register_pkg::*;
#(
    parameter int               WIDTH       = SM_REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SM_REG_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef SM_REGISTER_WE_EN
    ,
    input  logic             we
`endif
);

    if (WIDTH < 1) begin : g_width_check
        $error("sm_register: WIDTH must be at least 1");
    end

`ifdef SM_REGISTER_WE_EN
    sm_register_we #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q),
        .we    (we)
    );
`else
    // Port order stays positional-compatible with older instantiations like r_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end
`endif

endmodule

// File: tb/tb_sm_register.sv
// Self-checking bench for sm_register: default 32-bit PC instance plus an 8-bit instance
// with a non-zero reset value. Write-enable checks compile in with SM_REGISTER_WE_EN.
module tb_sm_register;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] d;
    logic [31:0] q;
    logic [7:0]  d8;
    logic [7:0]  q8;
`ifdef SM_REGISTER_WE_EN
    logic        we;
`endif

    int n_checks;
    int n_fail;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] last_q;
    logic [31:0] model_pc;

    sm_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q)
`ifdef SM_REGISTER_WE_EN
        ,
        .we    (we)
`endif
    );

    sm_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d8),
        .q     (q8)
`ifdef SM_REGISTER_WE_EN
        ,
        .we    (we)
`endif
    );

    // Clock is gated so the first reset check happens with no edges at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive d, confirm q has not followed it combinationally, then score the captured value.
    task automatic apply_stimulus(input logic [31:0] dv, input logic [31:0] expv, input string tag);
        logic [31:0] e;
        string       t;
        d = dv;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #1;
        check_output({tag, "_pre_edge"}, q, last_q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_output(t, q, e);
        last_q = expv;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        d        = 32'hDEAD_BEEF;
        d8       = 8'h3C;
`ifdef SM_REGISTER_WE_EN
        we       = 1'b1;
`endif

        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_async", q, 32'h0);
        check_output("reset_async_w8", {24'h0, q8}, 32'h0000_00A5);

        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_dominates", q, 32'h0);
        check_output("reset_dominates_w8", {24'h0, q8}, 32'h0000_00A5);

        rst_n  = 1'b1;
        last_q = 32'h0;
        apply_stimulus(32'h0000_0001, 32'h0000_0001, "capture1");
        check_output("param_capture_w8", {24'h0, q8}, 32'h0000_003C);
        apply_stimulus(32'h0000_0002, 32'h0000_0002, "capture2");

        // PC increment loop from a fresh reset.
        rst_n = 1'b0;
        #1;
        check_output("pc_reset", q, 32'h0);
        rst_n    = 1'b1;
        last_q   = 32'h0;
        model_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            model_pc = model_pc + 32'd1;
            apply_stimulus(model_pc, model_pc, $sformatf("pc_count%0d", i + 1));
        end

        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, "pc_max");
        model_pc = 32'hFFFF_FFFF;
        model_pc = model_pc + 32'd1;
        apply_stimulus(model_pc, 32'h0, "pc_wrap");
        apply_stimulus(32'hA5A5_5A5A, 32'hA5A5_5A5A, "pattern");

        // Reset pulled between edges must clear q before the next rising edge.
        apply_stimulus(32'h0000_0010, 32'h0000_0010, "pre_mid_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("mid_reset", q, 32'h0);
        check_output("mid_reset_w8", {24'h0, q8}, 32'h0000_00A5);
        rst_n  = 1'b1;
        last_q = 32'h0;
        apply_stimulus(32'h0000_0055, 32'h0000_0055, "post_release");

`ifdef SM_REGISTER_WE_EN
        we = 1'b0;
        apply_stimulus(32'h0000_1234, 32'h0000_0055, "we_hold");
        we = 1'b1;
        apply_stimulus(32'h0000_1234, 32'h0000_1234, "we_load");
        rst_n = 1'b0;
        #1;
        check_output("we_reset", q, 32'h0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
